// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register slice.
// shift_mode_t is the 2-bit operation select carried on the mode port.
package shiftreg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/shift_word_counter.sv
// Counts shifts and raises a one-cycle word_done strobe every WIDTH shifts.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset (cnt=0, word_done=0)
//   shift_en  - a shift (either direction) happens on this edge
//   clear     - parallel load on this edge: cnt=0, no strobe (beats shift_en)
//   cnt       - shifts taken in the current word
//   word_done - registered strobe, high for the cycle after the WIDTH-th shift
module shift_word_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift_en,
    input  logic                     clear,
    output logic [$clog2(WIDTH)-1:0] cnt,
    output logic                     word_done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (clear) begin
                cnt <= '0;
            end else if (shift_en) begin
                if (cnt == LAST) begin
                    cnt       <= '0;
                    word_done <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/universal_shiftreg.sv
// WIDTH-bit universal shift register: hold, shift right, shift left, load.
// Optional rotate mode is built when UNIVERSAL_SHIFTREG_ROTATE_EN is defined.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset (q=RESET_VAL)
//   mode      - 00 hold, 01 shift right, 10 shift left, 11 parallel load
//   si        - serial in (MSB on shift right, LSB on shift left)
//   pin       - parallel load data
//   rot       - rotate instead of taking si (only with the macro defined)
//   q         - registered contents
//   so_r      - serial out for right shift, q[0]
//   so_l      - serial out for left shift, q[WIDTH-1]
//   word_done - one-cycle strobe after every WIDTH shifts
module universal_shiftreg
    import shiftreg_pkg::*;
#(
    parameter int unsigned          WIDTH     = 8,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pin,
`ifdef UNIVERSAL_SHIFTREG_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             so_r,
    output logic             so_l,
    output logic             word_done
);

    shift_mode_t             mode_s;
    logic                    fill_r;
    logic                    fill_l;
    logic [$clog2(WIDTH)-1:0] cnt_unused;

    assign mode_s = shift_mode_t'(mode);

    // Bit entering the vacated end: wraps the outgoing bit when rotating.
`ifdef UNIVERSAL_SHIFTREG_ROTATE_EN
    assign fill_r = rot ? q[0]       : si;
    assign fill_l = rot ? q[WIDTH-1] : si;
`else
    assign fill_r = si;
    assign fill_l = si;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else begin
            unique case (mode_s)
                MODE_SHR:  q <= {fill_r, q[WIDTH-1:1]};
                MODE_SHL:  q <= {q[WIDTH-2:0], fill_l};
                MODE_LOAD: q <= pin;
                default:   q <= q;
            endcase
        end
    end

    assign so_r = q[0];
    assign so_l = q[WIDTH-1];

    shift_word_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .clk       (clk),
        .reset     (reset),
        .shift_en  ((mode_s == MODE_SHR) || (mode_s == MODE_SHL)),
        .clear     (mode_s == MODE_LOAD),
        .cnt       (cnt_unused),
        .word_done (word_done)
    );

endmodule
